router_out_fifo: RTL and testbench
==================================

Name: router_out_fifo

Overview:
- Per-destination output buffer of the 1x3 router. Three instances sit between the input register/FSM stage and the three output ports.
- Stores packet bytes tagged with a header flag and presents them on data_out under read_enb / vld_out.
- Tracks packet boundaries on the read side.
- Flushes itself (soft reset) when the destination does not read for TIMEOUT cycles.

Parameters:
- DEPTH, 16, number of entries (power of two, >= 4).
- WIDTH, 8, data byte width.
- TIMEOUT, 30, consecutive cycles of vld_out=1 with read_enb=0 before a flush.

Ports:
- clock  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- we  in  1  write strobe from the input stage.
- lfd  in  1  marks data_in as the header byte (first byte of a packet).
- data_in  in  WIDTH  byte to store.
- read_enb  in  1  read request from the destination.
- data_out  out  WIDTH  registered read data.
- vld_out  out  1  FIFO not empty (equals !empty).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- soft_rst  out  1  one-cycle pulse when a timeout flush occurs.
- pkt_last  out  1  one-cycle pulse aligned with data_out carrying the parity byte.

Behaviour:
- Reset: rst sampled low at a posedge clears the following; rst low mid-packet discards all stored data.
  - Pointers, count, timeout counter and packet counter go to 0.
  - data_out=0, soft_rst=0, pkt_last=0.
  - Hence empty=1, vld_out=0, full=0.
- Storage: each entry holds {hdr, data}, WIDTH+1 bits. The entry is written as {lfd, data_in}.
- Write: on a posedge with we=1 and full=0, the entry is stored at wr_ptr and wr_ptr increments mod DEPTH.
  - we=1 while full=1: write dropped, no state change.
- Read: on a posedge with read_enb=1 and empty=0, the entry at rd_ptr is registered onto data_out and rd_ptr increments mod DEPTH. Latency is 1 cycle: data_out is valid the cycle after the read.
  - read_enb=1 while empty=1: ignored, data_out holds its last value.
- Count update:
  - Simultaneous valid read and write: count unchanged.
  - Write at full=1 is blocked even if a read occurs the same cycle, because full comes from the registered count.
  - Read and write in the same cycle at count=0: only the write takes effect.
- Pointer width: $clog2(DEPTH). The count is one bit wider. Wrap is natural mod-DEPTH.
- Packet tracking (read side): 6-bit pkt_rem.
  - On reading an entry with hdr=1: pkt_rem <= data[7:2] + 1, covering payload plus parity.
  - On reading an entry with hdr=0 and pkt_rem != 0: pkt_rem decrements.
  - When that decrement takes pkt_rem from 1 to 0, pkt_last=1 in the same cycle data_out shows that byte.
  - A header read while pkt_rem != 0 reloads pkt_rem (truncated packet), and no pkt_last is issued for the old packet.
- Timeout:
  - 5-bit tmo_cnt increments each cycle with vld_out=1 and read_enb=0.
  - It clears on any cycle with read_enb=1 or vld_out=0.
  - When tmo_cnt == TIMEOUT-1 and the condition still holds, the next posedge flushes:
    - Pointers, count, pkt_rem and tmo_cnt go to 0.
    - data_out=0, soft_rst=1 for exactly 1 cycle.
  - A write in the flush cycle is dropped; the flush wins.
- Outputs full, empty and vld_out are combinational decodes of the registered count. All other outputs are registered.

Decomposition:
- router_pkg:
  - fifo_entry_t packed struct {logic hdr; logic [7:0] data}.
  - ROUTER_FIFO_DEPTH=16.
  - ROUTER_TIMEOUT=30.
  - Helper constant HDR_LEN_MSB=7, HDR_LEN_LSB=2.
- Sub-module router_fifo_mem: DEPTH x fifo_entry_t register array with one write port and one synchronous read port. Pointer, count, packet and timeout logic stay in router_out_fifo.

Test Plan:
- Reset/empty: rst=0 for 2 cycles, then read_enb=1 -> data_out=0, empty=1, vld_out=0, soft_rst=0 throughout.
- Packet pass-through: write header 8'h0C (len 3, lfd=1), payload 8'h11, 8'h22, 8'h33, parity 8'h2E, then read_enb=1 for 5 cycles -> data_out sequence 0C,11,22,33,2E each 1 cycle after its read; pkt_last=1 only with 2E; empty=1 afterwards.
- Full/wrap: write 16 bytes 0x00..0x0F -> full=1; a 17th write of 0xFF is dropped. Then read 8, write 8 more (0x10..0x17), read 16 -> output 0x08..0x17 in order, no 0xFF.
- Simultaneous read/write at count 5 for 10 cycles -> count stays 5, full=0, empty=0, data ordering preserved.
- Timeout: write 3 bytes, hold read_enb=0 -> soft_rst pulses exactly on the 31st cycle after vld_out rose. Afterwards empty=1, data_out=0. A write in the flush cycle leaves empty=1.
- Mid-packet reset: write 4 bytes, read 2, assert rst=0 for 1 cycle -> empty=1, pkt_last never fires, next header read reloads pkt_rem correctly.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the router output buffers.
package router_pkg;
  localparam int ROUTER_FIFO_DEPTH = 16;
  localparam int ROUTER_TIMEOUT    = 30;
  localparam int HDR_LEN_MSB       = 7;
  localparam int HDR_LEN_LSB       = 2;

  typedef struct packed {
    logic       hdr;
    logic [7:0] data;
  } fifo_entry_t;
endpackage

// File: rtl/router_fifo_mem.sv
// Entry storage: one write port, registered read port (1-cycle latency), plus a head peek.
// No flow control here; the caller gates wr_en/rd_en.
module router_fifo_mem
  import router_pkg::*;
#(
  parameter  int DEPTH = ROUTER_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  fifo_entry_t   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output fifo_entry_t   rd_head,
  output fifo_entry_t   rd_data
);
  fifo_entry_t mem_q [DEPTH];
  fifo_entry_t rd_q;

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (!rst || clr)  rd_q <= '0;
    else if (rd_en)   rd_q <= mem_q[rd_addr];
  end

  // Packet tracking needs the entry being popped in the same cycle.
  assign rd_head = mem_q[rd_addr];
  assign rd_data = rd_q;
endmodule

// File: rtl/router_out_fifo.sv
// Per-destination output FIFO: 1-cycle read latency; writes dropped when full,
// reads ignored when empty; self-flushes after TIMEOUT unserviced cycles.
module router_out_fifo
  import router_pkg::*;
#(
  parameter int DEPTH   = ROUTER_FIFO_DEPTH,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = ROUTER_TIMEOUT
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             we,
  input  logic             lfd,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             vld_out,
  output logic             full,
  output logic             empty,
  output logic             soft_rst,
  output logic             pkt_last
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [5:0]    pkt_rem_q, pkt_rem_d;
  logic [4:0]    tmo_q, tmo_d;
  logic          soft_rst_q, soft_rst_d, pkt_last_q, pkt_last_d;
  logic          stall, tmo_hit, wr_ok, rd_ok;
  fifo_entry_t   wr_entry, rd_head, rd_data;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign vld_out = ~empty;

  assign stall   = vld_out & ~read_enb;
  assign tmo_hit = stall && (tmo_q == 5'(TIMEOUT - 1));
  // The flush wins over a concurrent write.
  assign wr_ok   = we & ~full & ~tmo_hit;
  assign rd_ok   = read_enb & ~empty;

  assign wr_entry = '{hdr: lfd, data: data_in};

  router_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clock   (clock),
    .rst     (rst),
    .clr     (tmo_hit),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_entry),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr_q),
    .rd_head (rd_head),
    .rd_data (rd_data)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    pkt_rem_d  = pkt_rem_q;
    tmo_d      = tmo_q;
    soft_rst_d = 1'b0;
    pkt_last_d = 1'b0;
    if (tmo_hit) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
      pkt_rem_d  = '0;
      tmo_d      = '0;
      soft_rst_d = 1'b1;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        // Header length covers payload; +1 accounts for the trailing parity byte.
        if (rd_head.hdr) begin
          pkt_rem_d = rd_head.data[HDR_LEN_MSB:HDR_LEN_LSB] + 6'd1;
        end else if (pkt_rem_q != 6'd0) begin
          pkt_rem_d  = pkt_rem_q - 6'd1;
          pkt_last_d = (pkt_rem_q == 6'd1);
        end
      end
      case ({wr_ok, rd_ok})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
      tmo_d = stall ? tmo_q + 5'd1 : 5'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      pkt_rem_q  <= '0;
      tmo_q      <= '0;
      soft_rst_q <= 1'b0;
      pkt_last_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      pkt_rem_q  <= pkt_rem_d;
      tmo_q      <= tmo_d;
      soft_rst_q <= soft_rst_d;
      pkt_last_q <= pkt_last_d;
    end
  end

  assign data_out = rd_data.data;
  assign soft_rst = soft_rst_q;
  assign pkt_last = pkt_last_q;
endmodule

// File: tb/tb_router_out_fifo.sv
// Directed bench for router_out_fifo: reset, packet flow, full/wrap, streaming, timeout, resets.
module tb_router_out_fifo;
  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic       we = 1'b0;
  logic       lfd = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       read_enb = 1'b0;
  logic [7:0] data_out;
  logic       vld_out, full, empty, soft_rst, pkt_last;

  int total = 0;
  int bad = 0;

  router_out_fifo dut (
    .clock    (clock),
    .rst      (rst),
    .we       (we),
    .lfd      (lfd),
    .data_in  (data_in),
    .read_enb (read_enb),
    .data_out (data_out),
    .vld_out  (vld_out),
    .full     (full),
    .empty    (empty),
    .soft_rst (soft_rst),
    .pkt_last (pkt_last)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic h);
    we = 1'b1; data_in = d; lfd = h;
    tick();
    we = 1'b0; lfd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data_out); end
    total++; if ({empty, vld_out, full, soft_rst, pkt_last} !== 5'b10000) begin bad++;
      $display("FAIL reset_flags got=%b exp=10000", {empty, vld_out, full, soft_rst, pkt_last}); end
    rst = 1'b1; read_enb = 1'b1;
    tick(); tick();
    total++; if ({data_out, empty, vld_out, soft_rst} !== {8'h00, 3'b100}) begin bad++;
      $display("FAIL reset_empty_read got=%h/%b exp=00/100", data_out, {empty, vld_out, soft_rst}); end
    read_enb = 1'b0;
  endtask

  task automatic test_packet();
    logic [7:0] exp [5] = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h2E};
    push(8'h0C, 1'b1);
    for (int i = 1; i < 5; i++) push(exp[i], 1'b0);
    read_enb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (data_out !== exp[i]) begin bad++; $display("FAIL pkt_data[%0d] got=%h exp=%h", i, data_out, exp[i]); end
      total++; if (pkt_last !== (i == 4)) begin bad++; $display("FAIL pkt_last[%0d] got=%b exp=%b", i, pkt_last, (i == 4)); end
    end
    read_enb = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL pkt_empty got=%b exp=1", empty); end
    tick();
    total++; if (pkt_last !== 1'b0) begin bad++; $display("FAIL pkt_last_pulse got=%b exp=0", pkt_last); end
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 16; i++) begin
      total++; if (full !== 1'b0) begin bad++; $display("FAIL fill_notfull[%0d] got=%b exp=0", i, full); end
      push(8'(i), 1'b0);
    end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL full_set got=%b exp=1", full); end
    push(8'hFF, 1'b0);
    total++; if (full !== 1'b1) begin bad++; $display("FAIL full_after_drop got=%b exp=1", full); end
    read_enb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++; if (data_out !== 8'(i)) begin bad++; $display("FAIL wrap_rd1[%0d] got=%h exp=%h", i, data_out, 8'(i)); end
    end
    read_enb = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i), 1'b0);
    total++; if (full !== 1'b1) begin bad++; $display("FAIL full_wrapped got=%b exp=1", full); end
    read_enb = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      total++; if (data_out !== 8'(8'h08 + i)) begin bad++; $display("FAIL wrap_rd2[%0d] got=%h exp=%h", i, data_out, 8'(8'h08 + i)); end
      total++; if (pkt_last !== 1'b0) begin bad++; $display("FAIL wrap_pkt_last[%0d] got=%b exp=0", i, pkt_last); end
    end
    read_enb = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", empty); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    for (int i = 0; i < 5; i++) push(8'(8'hA0 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      we = 1'b1; data_in = 8'(8'hB0 + i); read_enb = 1'b1;
      tick();
      exp = (i < 5) ? 8'(8'hA0 + i) : 8'(8'hB0 + i - 5);
      total++; if (data_out !== exp) begin bad++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, data_out, exp); end
      total++; if ({full, empty} !== 2'b00) begin bad++; $display("FAIL b2b_flags[%0d] got=%b exp=00", i, {full, empty}); end
    end
    we = 1'b0;
    for (int i = 5; i < 10; i++) begin
      tick();
      total++; if (data_out !== 8'(8'hB0 + i)) begin bad++; $display("FAIL b2b_drain[%0d] got=%h exp=%h", i, data_out, 8'(8'hB0 + i)); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b exp=1", empty); end
    tick();
    total++; if (data_out !== 8'hB9) begin bad++; $display("FAIL empty_read_hold got=%h exp=b9", data_out); end
    read_enb = 1'b0;
  endtask

  task automatic test_timeout();
    push(8'h01, 1'b0);
    total++; if (vld_out !== 1'b1) begin bad++; $display("FAIL tmo_vld_rise got=%b exp=1", vld_out); end
    push(8'h02, 1'b0);
    push(8'h03, 1'b0);
    for (int n = 4; n <= 31; n++) begin
      if (n == 31) begin we = 1'b1; data_in = 8'hEE; end
      tick();
      if (n < 31) begin
        total++; if (soft_rst !== 1'b0) begin bad++; $display("FAIL tmo_early[%0d] got=%b exp=0", n, soft_rst); end
      end else begin
        total++; if (soft_rst !== 1'b1) begin bad++; $display("FAIL tmo_pulse got=%b exp=1", soft_rst); end
        total++; if ({empty, data_out} !== {1'b1, 8'h00}) begin bad++;
          $display("FAIL tmo_flush got=%b/%h exp=1/00", empty, data_out); end
      end
    end
    we = 1'b0;
    tick();
    total++; if ({soft_rst, empty} !== 2'b01) begin bad++; $display("FAIL tmo_after got=%b exp=01", {soft_rst, empty}); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] exp [3] = '{8'h04, 8'h55, 8'h51};
    push(8'h10, 1'b1);
    push(8'h41, 1'b0);
    push(8'h42, 1'b0);
    push(8'h43, 1'b0);
    read_enb = 1'b1;
    tick();
    total++; if (data_out !== 8'h10) begin bad++; $display("FAIL mid_rd0 got=%h exp=10", data_out); end
    tick();
    total++; if (data_out !== 8'h41) begin bad++; $display("FAIL mid_rd1 got=%h exp=41", data_out); end
    read_enb = 1'b0; rst = 1'b0;
    tick();
    rst = 1'b1;
    total++; if ({empty, pkt_last, data_out} !== {2'b10, 8'h00}) begin bad++;
      $display("FAIL mid_reset got=%b/%h exp=10/00", {empty, pkt_last}, data_out); end
    push(8'h04, 1'b1);
    push(8'h55, 1'b0);
    push(8'h51, 1'b0);
    read_enb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (data_out !== exp[i]) begin bad++; $display("FAIL mid_new_data[%0d] got=%h exp=%h", i, data_out, exp[i]); end
      total++; if (pkt_last !== (i == 2)) begin bad++; $display("FAIL mid_new_last[%0d] got=%b exp=%b", i, pkt_last, (i == 2)); end
    end
    read_enb = 1'b0;
  endtask

  task automatic test_truncated();
    logic [7:0] exp [5] = '{8'h08, 8'h61, 8'h04, 8'h71, 8'h72};
    push(8'h08, 1'b1);
    push(8'h61, 1'b0);
    push(8'h04, 1'b1);
    push(8'h71, 1'b0);
    push(8'h72, 1'b0);
    read_enb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (data_out !== exp[i]) begin bad++; $display("FAIL trunc_data[%0d] got=%h exp=%h", i, data_out, exp[i]); end
      total++; if (pkt_last !== (i == 4)) begin bad++; $display("FAIL trunc_last[%0d] got=%b exp=%b", i, pkt_last, (i == 4)); end
    end
    read_enb = 1'b0;
  endtask

  initial begin
    test_reset();
    test_packet();
    test_full_wrap();
    test_back_to_back();
    test_timeout();
    test_mid_reset();
    test_truncated();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
